div_issue_queue: RTL and testbench

- Sequential front-end for the 4-bit signed combinational divider.
- Buffers operand pairs in a small FIFO and presents the head entry to the divider.
- Registers the divider's quotient/remainder into an output slot with a valid/ready handshake.
- Tags each result with divide-by-zero and signed-overflow flags.

---
 rtl/div_issue_queue.sv | 103 ++++++++++
 tb/tb_div_issue_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_queue.sv
// Operand FIFO and registered result slot wrapped around an external
// combinational 4-bit signed divider. Results leave in acceptance order.
module div_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_dividend,
    input  logic [3:0]    in_divisor,
    output logic [3:0]    div_dividend,
    output logic [3:0]    div_divisor,
    input  logic [3:0]    div_quotient,
    input  logic [3:0]    div_remainder,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_quotient,
    output logic [3:0]    out_remainder,
    output logic          out_div0,
    output logic          out_ovf,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high. valid never waits on ready, and a producer holding valid
    // keeps its payload stable until the transfer.
    logic [3:0]    mem_dividend [DEPTH];
    logic [3:0]    mem_divisor  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          full;
    logic          push;
    logic          load;
    logic          head_div0;
    logic          head_ovf;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign load     = ~empty & (~out_valid | out_ready);
    assign count    = count_q;

    // The divider sees zeros while the queue is empty so it never works on stale data.
    assign div_dividend = empty ? 4'b0000 : mem_dividend[rd_ptr];
    assign div_divisor  = empty ? 4'b0000 : mem_divisor[rd_ptr];

    assign head_div0 = (div_divisor == 4'b0000);
    assign head_ovf  = (div_dividend == 4'b1000) & (div_divisor == 4'b1111);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_dividend[wr_ptr] <= in_dividend;
            mem_divisor[wr_ptr]  <= in_divisor;
        end
    end

    // Pointers wrap naturally at DEPTH; fullness is tracked by count_q alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, load})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_quotient  <= 4'b0000;
            out_remainder <= 4'b0000;
            out_div0      <= 1'b0;
            out_ovf       <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            out_quotient  <= div_quotient;
            out_remainder <= div_remainder;
            out_div0      <= head_div0;
            out_ovf       <= head_ovf;
        end else if (out_valid & out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: divider stub, queue-based reference model,
// ordering scoreboard, table vectors and directed corner sequences.
module tb_div_issue_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_dividend = 4'h0;
    logic [3:0]    in_divisor = 4'h0;
    logic [3:0]    div_dividend;
    logic [3:0]    div_divisor;
    logic [3:0]    div_quotient;
    logic [3:0]    div_remainder;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_quotient;
    logic [3:0]    out_remainder;
    logic          out_div0;
    logic          out_ovf;
    logic [CW-1:0] count;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    div_issue_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_div0(out_div0), .out_ovf(out_ovf),
        .count(count)
    );

    // {quotient, remainder, div0, ovf} from plain signed integer arithmetic.
    function automatic logic [9:0] ref_div(input logic [3:0] a, input logic [3:0] b);
        int sa, sb, q, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = 0;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {4'(q), 4'(r), (sb == 0), (sa == -8 && sb == -1)};
    endfunction

    logic [9:0] stub_res;
    assign stub_res      = ref_div(div_dividend, div_divisor);
    assign div_quotient  = stub_res[9:6];
    assign div_remainder = stub_res[5:2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: operand queue plus a one-entry result slot.
    logic [7:0] m_fifo[$];
    bit         m_ov;
    logic [9:0] m_slot;
    logic [9:0] exp_q[$];
    bit         m_push, m_load;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            exp_q.delete();
            m_ov   = 0;
            m_slot = '0;
        end else begin
            m_push = in_valid && (m_fifo.size() < DEPTH);
            m_load = (m_fifo.size() != 0) && (!m_ov || out_ready);
            if (m_load) begin
                m_slot = ref_div(m_fifo[0][7:4], m_fifo[0][3:0]);
                void'(m_fifo.pop_front());
                m_ov = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (m_push) begin
                m_fifo.push_back({in_dividend, in_divisor});
                exp_q.push_back(ref_div(in_dividend, in_divisor));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("in_ready", in_ready, m_fifo.size() < DEPTH);
            chk("count", count, m_fifo.size());
            chk("out_valid", out_valid, m_ov);
            chk("out_slot", {out_quotient, out_remainder, out_div0, out_ovf}, m_slot);
            chk("div_operands", {div_dividend, div_divisor},
                (m_fifo.size() != 0) ? m_fifo[0] : 8'h00);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    chk("sb_underflow", 1, 0);
                else
                    chk("sb_order", {out_quotient, out_remainder, out_div0, out_ovf},
                        exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] a, input logic [3:0] b);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, {out_quotient, out_remainder, out_div0, out_ovf}, 0);
        chk({tag, "_div_ops"}, {div_dividend, div_divisor}, 0);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       d0;
        logic       ov;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0};
        tbl[1]  = '{4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 1'b0};
        tbl[2]  = '{4'd7, 4'hE, 4'hD, 4'd1, 1'b0, 1'b0};
        tbl[3]  = '{4'd5, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0};
        tbl[4]  = '{4'h8, 4'hF, 4'h8, 4'd0, 1'b0, 1'b1};
        tbl[5]  = '{4'h8, 4'd2, 4'hC, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{4'd0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[7]  = '{4'hF, 4'hF, 4'd1, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{4'h8, 4'd3, 4'hE, 4'hE, 1'b0, 1'b0};
        tbl[9]  = '{4'd6, 4'hC, 4'hF, 4'd2, 1'b0, 1'b0};
        tbl[10] = '{4'h8, 4'd0, 4'd0, 4'h8, 1'b1, 1'b0};

        // Reset state, sampled while reset is held.
        #12;
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk_en = 1;

        // Table vectors: one pair at a time, consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            offer(tbl[i].a, tbl[i].b);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_no_bypass", out_valid, 0);
            @(posedge clk);
            @(negedge clk);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_quotient", out_quotient, tbl[i].q);
            chk("tbl_remainder", out_remainder, tbl[i].r);
            chk("tbl_div0", out_div0, tbl[i].d0);
            chk("tbl_ovf", out_ovf, tbl[i].ov);
            chk("tbl_count", count, 0);
        end

        // Back-to-back pairs give results on consecutive cycles, in order.
        step();
        offer(4'h9, 4'd2);
        step();
        offer(4'd7, 4'hE);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_first", {out_valid, out_quotient, out_remainder}, {1'b1, 4'hD, 4'hF});
        @(posedge clk);
        @(negedge clk);
        chk("b2b_second", {out_valid, out_quotient, out_remainder}, {1'b1, 4'hD, 4'h1});

        // Backpressure: five accepted, sixth offer blocked while full.
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            offer(4'($urandom), 4'($urandom));
            step();
        end
        @(negedge clk);
        chk("bp_count_full", count, 4);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_drained_count", count, 0);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_drained_valid", out_valid, 0);

        // Refill to full, then stream with both sides always ready.
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(4'($urandom), 4'($urandom));
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            offer(4'($urandom), 4'($urandom));
            step();
            if (i >= 2) begin
                chk("stream_count", count, 3);
                chk("stream_in_ready", in_ready, 1);
                chk("stream_out_valid", out_valid, 1);
            end
        end
        in_valid = 1'b0;
        repeat (6) step();

        // Asynchronous reset mid-stream with count=3 and a held result.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(4'($urandom), 4'($urandom));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_count", count, 3);
        chk("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        offer(4'd3, 4'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_no_result", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_first", {out_valid, out_quotient, out_remainder, out_div0, out_ovf},
            {1'b1, 4'd3, 4'd0, 1'b0, 1'b0});

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step();
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 7) == 0) begin
                in_dividend = 4'h8;
                in_divisor  = 4'hF;
            end else begin
                in_dividend = 4'($urandom);
                in_divisor  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            end
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("final_sb_empty", exp_q.size(), 0);
        chk("final_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
